// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory stage.
// Holds the access FSM encoding, the link register index and the wait-counter width.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [4:0] JAL_LINK_REG   = 5'd31;
  localparam int         WAIT_CNT_WIDTH = 8;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: write enable, destination and write data.
// Latency 1 cycle; holds its contents whenever en is low (pipeline stall).
module mem_wb_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_register,
  output logic [DATA_WIDTH-1:0]     wb_write_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write      <= 1'b0;
      wb_write_register <= '0;
      wb_write_data     <= '0;
    end else if (en) begin
      wb_reg_write      <= reg_write;
      wb_write_register <= write_register;
      wb_write_data     <= write_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack access, branch decision and MEM/WB capture.
// Latency 1 cycle plus memory wait cycles; stalls upstream while an access is outstanding.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     ex_pc,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_read_data2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_register,
  input  logic                      ex_zero,
  input  logic                      ex_jal,
  input  logic                      ex_branch_eq,
  input  logic                      ex_branch_ne,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_mem_to_reg,
  input  logic                      ex_reg_write,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      stall,
  output logic                      branch_taken,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_register,
  output logic [DATA_WIDTH-1:0]     wb_write_data,
  output logic                      mem_error
);

  mem_state_e                state, state_next;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic                      access, legal, illegal, timeout;
  logic                      req_int, ack_seen, wb_en;
  logic [DATA_WIDTH-1:0]     load_data, write_data;
  logic [REG_ADDR_WIDTH-1:0] write_register;
  logic                      reg_write;

  assign access  = ex_mem_read | ex_mem_write;
  assign legal   = access & ~(ex_mem_read & ex_mem_write) & (ex_alu_result[1:0] == 2'b00);
  assign illegal = access & ~legal;
  // wait_cnt counts WAIT cycles already spent; the TIMEOUT_CYCLES-th one aborts
  assign timeout = (state == WAIT) &&
                   (wait_cnt == WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  assign branch_taken = (ex_branch_eq & ex_zero) | (ex_branch_ne & ~ex_zero);

  always_comb begin
    state_next = state;
    req_int    = 1'b0;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        req_int = legal;
        if (legal && !dmem_ack) begin
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        req_int = ~timeout;
        if (dmem_ack || timeout) state_next = IDLE;
        else                     stall      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Reset must drop the request in the same cycle, even with EX/MEM still holding an access
    if (!reset) begin
      req_int = 1'b0;
      stall   = 1'b0;
    end
  end

  assign dmem_req   = req_int;
  assign dmem_we    = req_int & ex_mem_write;
  assign dmem_addr  = req_int ? ex_alu_result : '0;
  assign dmem_wdata = req_int ? ex_read_data2 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_CNT_WIDTH'(1) : '0;
      if ((state == IDLE && illegal) || timeout) mem_error <= 1'b1;
    end
  end

  // An aborted load returns zero because ack_seen stays low
  assign ack_seen       = req_int & dmem_ack;
  assign load_data      = ack_seen ? dmem_rdata : '0;
  assign write_data     = ex_jal ? ex_pc : (ex_mem_to_reg ? load_data : ex_alu_result);
  assign write_register = ex_jal ? REG_ADDR_WIDTH'(JAL_LINK_REG) : ex_write_register;
  assign reg_write      = ex_reg_write & ~illegal;
  assign wb_en          = ~stall;

  mem_wb_register #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_mem_wb (
    .clk               (clk),
    .reset             (reset),
    .en                (wb_en),
    .reg_write         (reg_write),
    .write_register    (write_register),
    .write_data        (write_data),
    .wb_reg_write      (wb_reg_write),
    .wb_write_register (wb_write_register),
    .wb_write_data     (wb_write_data)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_pc, ex_alu_result, ex_read_data2;
  logic [4:0]  ex_write_register;
  logic        ex_zero, ex_jal, ex_branch_eq, ex_branch_ne;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, branch_taken, wb_reg_write, mem_error;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;

  int checks = 0;
  int errors = 0;
  int writes;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_pc             (ex_pc),
    .ex_alu_result     (ex_alu_result),
    .ex_read_data2     (ex_read_data2),
    .ex_write_register (ex_write_register),
    .ex_zero           (ex_zero),
    .ex_jal            (ex_jal),
    .ex_branch_eq      (ex_branch_eq),
    .ex_branch_ne      (ex_branch_ne),
    .ex_mem_read       (ex_mem_read),
    .ex_mem_write      (ex_mem_write),
    .ex_mem_to_reg     (ex_mem_to_reg),
    .ex_reg_write      (ex_reg_write),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .wb_reg_write      (wb_reg_write),
    .wb_write_register (wb_write_register),
    .wb_write_data     (wb_write_data),
    .mem_error         (mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nop();
    ex_pc = '0; ex_alu_result = '0; ex_read_data2 = '0; ex_write_register = '0;
    ex_zero = 1'b0; ex_jal = 1'b0; ex_branch_eq = 1'b0; ex_branch_ne = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    nop();
    ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    ex_alu_result = addr; ex_write_register = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop();
    reset = 1'b0;
    #2;
    chk("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
    chk("rst_wb_write_register", {27'b0, wb_write_register}, 32'd0);
    chk("rst_wb_write_data", wb_write_data, 32'd0);
    chk("rst_mem_error", {31'b0, mem_error}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Zero-wait load
    load(32'h10, 5'd8);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("zw_req", {31'b0, dmem_req}, 32'd1);
    chk("zw_we", {31'b0, dmem_we}, 32'd0);
    chk("zw_addr", dmem_addr, 32'h10);
    chk("zw_stall", {31'b0, stall}, 32'd0);
    step();
    nop();
    chk("zw_wb_data", wb_write_data, 32'h12345678);
    chk("zw_wb_reg", {27'b0, wb_write_register}, 32'd8);
    chk("zw_wb_we", {31'b0, wb_reg_write}, 32'd1);

    // Store, memory acks on the third request cycle
    nop();
    ex_mem_write = 1'b1; ex_alu_result = 32'h20; ex_read_data2 = 32'hCAFEBABE;
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_ack = (i == 2);
      @(negedge clk);
      chk("st_req", {31'b0, dmem_req}, 32'd1);
      chk("st_we", {31'b0, dmem_we}, 32'd1);
      chk("st_addr", dmem_addr, 32'h20);
      chk("st_wdata", dmem_wdata, 32'hCAFEBABE);
      chk("st_stall", {31'b0, stall}, (i < 2) ? 32'd1 : 32'd0);
      if (dmem_req && dmem_we && dmem_ack) writes++;
      step();
    end
    nop();
    chk("st_writes", writes, 32'd1);
    chk("st_wb_we", {31'b0, wb_reg_write}, 32'd0);
    chk("st_mem_error", {31'b0, mem_error}, 32'd0);

    // jal
    nop();
    ex_jal = 1'b1; ex_reg_write = 1'b1; ex_pc = 32'h00400008;
    ex_write_register = 5'd5; ex_alu_result = 32'h1234;
    @(negedge clk);
    chk("jal_req", {31'b0, dmem_req}, 32'd0);
    chk("jal_stall", {31'b0, stall}, 32'd0);
    step();
    nop();
    chk("jal_wb_reg", {27'b0, wb_write_register}, 32'd31);
    chk("jal_wb_data", wb_write_data, 32'h00400008);
    chk("jal_wb_we", {31'b0, wb_reg_write}, 32'd1);

    // Branch decision
    ex_branch_eq = 1'b1; ex_zero = 1'b1; #1;
    chk("beq_z1", {31'b0, branch_taken}, 32'd1);
    ex_branch_eq = 1'b0; ex_branch_ne = 1'b1; #1;
    chk("bne_z1", {31'b0, branch_taken}, 32'd0);
    ex_branch_eq = 1'b1; ex_branch_ne = 1'b0; ex_zero = 1'b0; #1;
    chk("beq_z0", {31'b0, branch_taken}, 32'd0);
    ex_branch_eq = 1'b0; ex_branch_ne = 1'b1; #1;
    chk("bne_z0", {31'b0, branch_taken}, 32'd1);
    step();

    // Misaligned load; a stray ack without a request must be ignored
    load(32'h22, 5'd9);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    step();
    nop();
    chk("mis_mem_error", {31'b0, mem_error}, 32'd1);
    chk("mis_wb_we", {31'b0, wb_reg_write}, 32'd0);

    // Reset clears the sticky error
    reset = 1'b0; #2;
    chk("rst2_mem_error", {31'b0, mem_error}, 32'd0);
    reset = 1'b1;
    step();

    // Zero-wait load immediately followed by a load that times out
    load(32'h30, 5'd7);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    step();
    load(32'h40, 5'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("to_stall", {31'b0, stall}, (i < 4) ? 32'd1 : 32'd0);
      chk("to_req", {31'b0, dmem_req}, (i < 4) ? 32'd1 : 32'd0);
      if (i == 2) chk("to_hold_data", wb_write_data, 32'hA5A5A5A5);
      step();
    end
    nop();
    chk("to_mem_error", {31'b0, mem_error}, 32'd1);
    chk("to_wb_data", wb_write_data, 32'd0);
    chk("to_wb_reg", {27'b0, wb_write_register}, 32'd10);
    chk("to_wb_we", {31'b0, wb_reg_write}, 32'd1);

    // Reset while waiting drops the request immediately
    load(32'h44, 5'd11);
    step();
    @(negedge clk);
    chk("rw_req_before", {31'b0, dmem_req}, 32'd1);
    chk("rw_stall_before", {31'b0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_req_async", {31'b0, dmem_req}, 32'd0);
    chk("rw_stall_async", {31'b0, stall}, 32'd0);
    chk("rw_mem_error", {31'b0, mem_error}, 32'd0);
    chk("rw_wb_data", wb_write_data, 32'd0);
    nop();
    step();
    reset = 1'b1;
    step();
    chk("rw_req_after", {31'b0, dmem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
